// File: rtl/img_rd_arbiter_pkg.sv
// Shared constants, return-tag type and round-robin helper for the image memory read arbiter.
package img_rd_arbiter_pkg;

  localparam int IMG_ADDR_W = 32;
  localparam int IMG_DATA_W = 16;
  localparam int MAX_N_REQ  = 8;
  localparam int TAG_IDX_W  = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

  // One-hot winner: first set request strictly after ptr, wrapping modulo n.
  function automatic logic [MAX_N_REQ-1:0] rr_pick(input logic [MAX_N_REQ-1:0] req,
                                                   input logic [TAG_IDX_W-1:0] ptr,
                                                   input int n);
    logic [MAX_N_REQ-1:0] pick;
    logic [TAG_IDX_W-1:0] idx;
    logic                 found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N_REQ; k++) begin
      idx = TAG_IDX_W'((int'(ptr) + k) % n);
      if (k <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/img_rd_arbiter_if.sv
// Requester and memory-side signals of the image read arbiter, bundled with arbiter/environment views.
interface img_rd_arbiter_if
  import img_rd_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = IMG_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req, lock, addr, mem_rdata,
    output gnt, rvalid, rdata, mem_rd_en, mem_addr
  );

  modport master (
    output req, lock, addr, mem_rdata,
    input  gnt, rvalid, rdata, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/img_rd_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, requester index} alongside each in-flight memory read.
module rd_tag_pipe
  import img_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  // Reset flushes every stage so reads issued before reset never return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/img_rd_arbiter.sv
// Round-robin arbiter with burst lock for the image memory read port; returns routed by tag pipeline.
module img_rd_arbiter
  import img_rd_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = IMG_ADDR_W,
  parameter int DATA_W    = IMG_DATA_W,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  img_rd_arbiter_if.slave   bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]        rrPtr_q, rrPtr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 lockValid_q, lockValid_d;
  logic [CW-1:0]        burstCnt_q, burstCnt_d;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     rrGnt;
  logic [MAX_N_REQ-1:0] rrPick;
  logic [IW-1:0]        gIdx;
  logic                 othersReq;
  logic                 ownerHolds;
  logic [N_REQ-1:0]     rvalid;
  rd_tag_t              tagIn, tagOut;

  // A locked owner keeps the port unless it has used up its burst while someone else waits.
  always_comb begin
    rrPick    = rr_pick(MAX_N_REQ'(bus.req), TAG_IDX_W'(rrPtr_q), N_REQ);
    rrGnt     = rrPick[N_REQ-1:0];
    othersReq = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) != owner_q && bus.req[i]) othersReq = 1'b1;
    end
    ownerHolds = lockValid_q && bus.req[owner_q]
                 && !(burstCnt_q == CW'(MAX_BURST) && othersReq);
    gnt = '0;
    if (rst_n) begin
      if (ownerHolds) gnt[owner_q] = 1'b1;
      else            gnt = rrGnt;
    end
    gIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gIdx = IW'(i);
    end
  end

  assign bus.gnt       = gnt;
  assign bus.mem_rd_en = |gnt;
  assign bus.mem_addr  = (|gnt) ? bus.addr[gIdx*ADDR_W +: ADDR_W] : '0;

  always_comb begin
    rrPtr_d     = rrPtr_q;
    owner_d     = owner_q;
    lockValid_d = 1'b0;
    burstCnt_d  = burstCnt_q;
    if (|gnt) begin
      rrPtr_d     = gIdx;
      owner_d     = gIdx;
      lockValid_d = bus.lock[gIdx];
      if (lockValid_q && gIdx == owner_q) begin
        burstCnt_d = (burstCnt_q == CW'(MAX_BURST)) ? burstCnt_q : burstCnt_q + CW'(1);
      end else begin
        burstCnt_d = CW'(1);
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrPtr_q     <= IW'(N_REQ - 1);
      owner_q     <= '0;
      lockValid_q <= 1'b0;
      burstCnt_q  <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      owner_q     <= owner_d;
      lockValid_q <= lockValid_d;
      burstCnt_q  <= burstCnt_d;
    end
  end

  always_comb begin
    tagIn.valid = |gnt;
    tagIn.idx   = TAG_IDX_W'(gIdx);
  end

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tagIn),
    .tag_o (tagOut)
  );

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid[i] = tagOut.valid && (tagOut.idx == TAG_IDX_W'(i));
    end
  end

  assign bus.rvalid = rvalid;
  assign bus.rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_img_rd_arbiter.sv
// Directed bench for img_rd_arbiter: per-cycle arbitration/return model plus literal expectations.
module tb_img_rd_arbiter;
  import img_rd_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LAT = 2;
  localparam int MB = 16;

  typedef struct {
    int          idx;
    logic [31:0] a;
    int          due;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;
  int   asserts = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  img_rd_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  img_rd_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // Image memory stand-in: returns memFn(address) exactly LAT cycles after each read.
  logic [32:0] mp0, mp1;
  always @(posedge clk) begin
    mp0 <= {bus.mem_rd_en, bus.mem_addr};
    mp1 <= mp0;
  end
  assign bus.mem_rdata = mp1[32] ? memFn(mp1[31:0]) : 16'hDEAD;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.lock = l;
    rst_n    = rs;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] expGnt, input logic [AW-1:0] expAddr);
    @(negedge clk);
    compare({name, "_gnt"}, 64'(bus.gnt), 64'(expGnt));
    compare({name, "_addr"}, 64'(bus.mem_addr), 64'(expAddr));
  endtask

  task automatic checkReturn(input string name, input logic [N-1:0] expRv, input logic [DW-1:0] expData);
    compare({name, "_rvalid"}, 64'(bus.rvalid), 64'(expRv));
    if (expRv != '0) compare({name, "_rdata"}, 64'(bus.rdata), 64'(expData));
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs,
                      input string name, input logic [N-1:0] expGnt, input logic [AW-1:0] expAddr);
    applyStimulus(r, l, rs);
    checkOutput(name, expGnt, expAddr);
  endtask

  // Behavioural model: grant chosen from the arbitration rules, returns tracked as a due-time queue.
  initial begin : model
    int          mPtr, mOwner, mBurst, cyc, g, idx;
    bit          mLv, pipeKnown, others;
    logic [N-1:0] sReq, sLock, expGnt, expRv;
    logic        sRst;
    logic [N*AW-1:0] sAddr;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    ret_t        rq[$];
    mPtr = N - 1; mOwner = 0; mBurst = 0; mLv = 0; pipeKnown = 0; cyc = 0;
    forever begin
      @(negedge clk);
      sReq = bus.req; sLock = bus.lock; sRst = rst_n; sAddr = bus.addr;
      g = -1;
      if (sRst) begin
        others = 0;
        for (int i = 0; i < N; i++) if (i != mOwner && sReq[i]) others = 1;
        if (mLv && sReq[mOwner] && !(mBurst == MB && others)) g = mOwner;
        else begin
          for (int k = 1; k <= N; k++) begin
            idx = (mPtr + k) % N;
            if (g < 0 && sReq[idx]) g = idx;
          end
        end
      end
      expGnt  = (g >= 0) ? (N'(1) << g) : '0;
      expAddr = (g >= 0) ? sAddr[g*AW +: AW] : '0;
      compare("model_gnt", 64'(bus.gnt), 64'(expGnt));
      compare("model_rd_en", 64'(bus.mem_rd_en), 64'(g >= 0));
      compare("model_mem_addr", 64'(bus.mem_addr), 64'(expAddr));
      if (pipeKnown) begin
        expRv = '0; expData = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          expRv[rq[0].idx] = 1'b1;
          expData = memFn(rq[0].a);
          void'(rq.pop_front());
        end
        compare("model_rvalid", 64'(bus.rvalid), 64'(expRv));
        if (expRv != '0) compare("model_rdata", 64'(bus.rdata), 64'(expData));
      end
      @(posedge clk);
      if (!sRst) begin
        mPtr = N - 1; mOwner = 0; mBurst = 0; mLv = 0;
        rq.delete();
        pipeKnown = 1;
      end else if (g >= 0) begin
        rq.push_back('{g, expAddr, cyc + LAT});
        mBurst = (mLv && g == mOwner) ? ((mBurst < MB) ? mBurst + 1 : MB) : 1;
        mLv    = sLock[g];
        mOwner = g;
        mPtr   = g;
      end else begin
        mLv = 0;
      end
      cyc++;
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.req  = 3'b111;
    bus.lock = 3'b000;
    bus.addr = {32'h40, 32'h30, 32'h20};

    repeat (3) step(3'b111, 3'b000, 1'b0, "t1_reset", 3'b000, 32'h0);
    step(3'b111, 3'b000, 1'b1, "t1_first", 3'b001, 32'h20);

    step(3'b111, 3'b000, 1'b1, "t2_rr1", 3'b010, 32'h30);
    step(3'b111, 3'b000, 1'b1, "t2_rr2", 3'b100, 32'h40);
    checkReturn("t3_ret0", 3'b001, 16'h5A7A);
    step(3'b111, 3'b000, 1'b1, "t2_rr3", 3'b001, 32'h20);
    checkReturn("t3_ret1", 3'b010, 16'h5A6A);
    step(3'b000, 3'b000, 1'b1, "t3_idle1", 3'b000, 32'h0);
    checkReturn("t3_ret2", 3'b100, 16'h5A1A);
    step(3'b000, 3'b000, 1'b1, "t3_idle2", 3'b000, 32'h0);
    checkReturn("t3_ret0b", 3'b001, 16'h5A7A);
    step(3'b000, 3'b000, 1'b1, "t3_idle3", 3'b000, 32'h0);
    checkReturn("t3_drained", 3'b000, 16'h0);

    step(3'b001, 3'b001, 1'b1, "t4_lock_start", 3'b001, 32'h20);
    repeat (15) step(3'b011, 3'b001, 1'b1, "t4_burst", 3'b001, 32'h20);
    step(3'b011, 3'b001, 1'b1, "t4_limit", 3'b010, 32'h30);
    step(3'b011, 3'b001, 1'b1, "t4_back", 3'b001, 32'h20);

    repeat (40) step(3'b001, 3'b001, 1'b1, "t5_solo", 3'b001, 32'h20);
    step(3'b011, 3'b001, 1'b1, "t5_sat_yield", 3'b010, 32'h30);
    step(3'b000, 3'b000, 1'b1, "t5_release", 3'b000, 32'h0);

    step(3'b010, 3'b100, 1'b1, "lock_alone", 3'b010, 32'h30);
    step(3'b110, 3'b100, 1'b1, "lock_new_owner", 3'b100, 32'h40);
    step(3'b110, 3'b100, 1'b1, "lock_hold", 3'b100, 32'h40);

    step(3'b111, 3'b000, 1'b1, "t6_pre", 3'b100, 32'h40);
    step(3'b111, 3'b000, 1'b0, "t6_rst", 3'b000, 32'h0);
    checkReturn("t6_ret_before_rst", 3'b100, 16'h5A1A);
    repeat (3) begin
      step(3'b000, 3'b000, 1'b1, "t6_idle", 3'b000, 32'h0);
      checkReturn("t6_no_rvalid", 3'b000, 16'h0);
    end
    step(3'b111, 3'b000, 1'b1, "t6_rr_reset", 3'b001, 32'h20);
    repeat (4) step(3'b000, 3'b000, 1'b1, "drain", 3'b000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
